ps2_kb_matrix: RTL and testbench



---
 rtl/ps2_kb_matrix.sv | 195 +++++++++++++++++++
 tb/tb_ps2_kb_matrix.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_matrix.sv
// ps2_kb_matrix: PS/2 set-2 keyboard receiver driving a 40-key ZX matrix on KB[4:0].
// Define PS2_CURSOR_KEYS_EN to map cursor keys and Backspace onto CS+digit virtual presses.
module ps2_kb_matrix #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 14000
) (
    input  logic       CLK14,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic [7:0] A,
    output logic [4:0] KB,
    output logic       SCAN_VALID,
    output logic [7:0] SCAN_CODE,
    output logic       FRAME_ERR
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          edge_ev, dat, tmo, accept, err, hit, ovr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tmo_cnt;
    logic          ext, brk;
    logic [5:0]    idx;
    logic [39:0]   mat, eff;

    assign edge_ev = clk_filt_d & ~clk_filt;
    assign dat     = dat_sync[1];
    assign tmo     = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign ovr     = (shift == 8'h00) || (shift == 8'hFF);

    always_ff @(posedge CLK14 or posedge RESET) begin
        if (RESET) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], PS2_CLK};
            dat_sync   <= {dat_sync[0], PS2_DAT};
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt)
                filt_cnt <= '0;
            else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else
                filt_cnt <= filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK14 or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    // An edge in the same cycle as the timeout takes priority.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        err     = 1'b0;
        if (edge_ev) begin
            case (state)
                IDLE:    if (dat) err = 1'b1; else state_n = DATA;
                DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
                PARITY:  state_n = STOP;
                default: begin
                    state_n = IDLE;
                    accept  = dat & (^{shift, par});
                    err     = ~accept;
                end
            endcase
        end else if (tmo) begin
            err     = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge CLK14 or posedge RESET) begin
        if (RESET) begin
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= (state_n == IDLE || edge_ev) ? '0 : tmo_cnt + 1'b1;
            if (state == IDLE) bit_cnt <= '0;
            if (edge_ev && state == DATA) begin
                shift   <= {dat, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (edge_ev && state == PARITY) par <= dat;
        end
    end

    always_comb begin
        hit = ~ext;
        idx = 6'd0;
        case (shift)
            8'h12: idx = 6'd0;   8'h1A: idx = 6'd1;   8'h22: idx = 6'd2;   8'h21: idx = 6'd3;   8'h2A: idx = 6'd4;
            8'h1C: idx = 6'd5;   8'h1B: idx = 6'd6;   8'h23: idx = 6'd7;   8'h2B: idx = 6'd8;   8'h34: idx = 6'd9;
            8'h15: idx = 6'd10;  8'h1D: idx = 6'd11;  8'h24: idx = 6'd12;  8'h2D: idx = 6'd13;  8'h2C: idx = 6'd14;
            8'h16: idx = 6'd15;  8'h1E: idx = 6'd16;  8'h26: idx = 6'd17;  8'h25: idx = 6'd18;  8'h2E: idx = 6'd19;
            8'h45: idx = 6'd20;  8'h46: idx = 6'd21;  8'h3E: idx = 6'd22;  8'h3D: idx = 6'd23;  8'h36: idx = 6'd24;
            8'h4D: idx = 6'd25;  8'h44: idx = 6'd26;  8'h43: idx = 6'd27;  8'h3C: idx = 6'd28;  8'h35: idx = 6'd29;
            8'h5A: idx = 6'd30;  8'h4B: idx = 6'd31;  8'h42: idx = 6'd32;  8'h3B: idx = 6'd33;  8'h33: idx = 6'd34;
            8'h29: idx = 6'd35;  8'h14: idx = 6'd36;  8'h3A: idx = 6'd37;  8'h31: idx = 6'd38;  8'h32: idx = 6'd39;
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge CLK14 or posedge RESET) begin
        if (RESET) begin
            mat        <= '1;
            ext        <= 1'b0;
            brk        <= 1'b0;
            SCAN_VALID <= 1'b0;
            SCAN_CODE  <= 8'h00;
            FRAME_ERR  <= 1'b0;
        end else begin
            SCAN_VALID <= accept;
            FRAME_ERR  <= err;
            if (accept) SCAN_CODE <= shift;
            if (err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (accept) begin
                if (shift == 8'hE0)
                    ext <= 1'b1;
                else if (shift == 8'hF0)
                    brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (ovr)      mat      <= '1;
                    else if (hit) mat[idx] <= brk;
                end
            end
        end
    end

`ifdef PS2_CURSOR_KEYS_EN
    // vk bits (1 = held): Left, Down, Up, Right, Backspace -> CS plus digit 5, 6, 7, 8, 0.
    logic [4:0] vk;
    logic [2:0] vidx;
    logic       vhit;

    always_comb begin
        vhit = 1'b1;
        vidx = 3'd0;
        case ({ext, shift})
            9'h16B:  vidx = 3'd0;
            9'h172:  vidx = 3'd1;
            9'h175:  vidx = 3'd2;
            9'h174:  vidx = 3'd3;
            9'h066:  vidx = 3'd4;
            default: vhit = 1'b0;
        endcase
    end

    always_ff @(posedge CLK14 or posedge RESET) begin
        if (RESET)                 vk       <= '0;
        else if (accept && ovr)    vk       <= '0;
        else if (accept && vhit)   vk[vidx] <= ~brk;
    end

    always_comb begin
        eff     = mat;
        eff[0]  = mat[0]  & ~(|vk);
        eff[19] = mat[19] & ~vk[0];
        eff[24] = mat[24] & ~vk[1];
        eff[23] = mat[23] & ~vk[2];
        eff[22] = mat[22] & ~vk[3];
        eff[20] = mat[20] & ~vk[4];
    end
`else
    assign eff = mat;
`endif

    always_comb begin
        KB = 5'b11111;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!A[r]) KB[c] = KB[c] & eff[r*5+c];
    end
endmodule

// File: tb/tb_ps2_kb_matrix.sv
// tb_ps2_kb_matrix: directed and random PS/2 frames checked against a key-table model of the ZX matrix.
module tb_ps2_kb_matrix;
    localparam int TIMEOUT_CYC = 14000;

    logic       CLK14 = 1'b0, RESET = 1'b1, PS2_CLK = 1'b1, PS2_DAT = 1'b1;
    logic [7:0] A = 8'hFF;
    logic [4:0] KB;
    logic       SCAN_VALID, FRAME_ERR;
    logic [7:0] SCAN_CODE;

    always #5 CLK14 = ~CLK14;

    ps2_kb_matrix dut (
        .CLK14(CLK14), .RESET(RESET), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .A(A),
        .KB(KB), .SCAN_VALID(SCAN_VALID), .SCAN_CODE(SCAN_CODE), .FRAME_ERR(FRAME_ERR)
    );

    int n_cmp = 0, n_err = 0, sv_cnt = 0, fe_cnt = 0;
    logic [4:0] kb_at_sv = 5'b11111;

    always @(negedge CLK14) begin
        if (SCAN_VALID) begin
            sv_cnt++;
            kb_at_sv = KB;
        end
        if (FRAME_ERR) fe_cnt++;
    end

    // Set-2 codes of the ZX legends, row-major (row = A8..A15, columns 0..4).
    logic [7:0] keys [40] = '{
        8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h14, 8'h3A, 8'h31, 8'h32
    };
    bit         pressed [40];
    bit         m_ext, m_brk;
    logic [7:0] m_code;
`ifdef PS2_CURSOR_KEYS_EN
    logic [7:0] vcode [5] = '{8'h6B, 8'h72, 8'h75, 8'h74, 8'h66};
    bit         vext  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] vdig  [5] = '{8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h45};
    bit         vk    [5];
`endif

    task automatic model_reset();
        for (int i = 0; i < 40; i++) pressed[i] = 1'b0;
`ifdef PS2_CURSOR_KEYS_EN
        for (int v = 0; v < 5; v++) vk[v] = 1'b0;
`endif
        m_ext = 1'b0; m_brk = 1'b0; m_code = 8'h00;
    endtask

    task automatic model_apply(logic [7:0] b, bit ok);
        if (!ok) begin
            m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            m_code = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'h00 || b == 8'hFF) model_reset_keep(b);
            else begin
                for (int i = 0; i < 40; i++) if (!m_ext && keys[i] == b) pressed[i] = !m_brk;
`ifdef PS2_CURSOR_KEYS_EN
                for (int v = 0; v < 5; v++) if (vext[v] == m_ext && vcode[v] == b) vk[v] = !m_brk;
`endif
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end
    endtask

    task automatic model_reset_keep(logic [7:0] b);
        model_reset();
        m_code = b;
    endtask

    function automatic bit key_down(int i);
        bit d = pressed[i];
`ifdef PS2_CURSOR_KEYS_EN
        for (int v = 0; v < 5; v++) if (vk[v] && (keys[i] == 8'h12 || keys[i] == vdig[v])) d = 1'b1;
`endif
        return d;
    endfunction

    function automatic logic [4:0] kb_model(logic [7:0] a);
        logic [4:0] k = 5'b11111;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!a[r] && key_down(r*5 + c)) k[c] = 1'b0;
        return k;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(bit v);
        PS2_DAT = v;
        repeat (20) @(posedge CLK14);
        PS2_CLK = 1'b0;
        repeat (20) @(posedge CLK14);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] b, bit bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(1'b1);
        PS2_DAT = 1'b1;
        repeat (20) @(posedge CLK14);
    endtask

    task automatic frame(logic [7:0] b, bit bad);
        int sv0 = sv_cnt, fe0 = fe_cnt;
        send_frame(b, bad);
        model_apply(b, !bad);
        @(negedge CLK14);
        check("scan_valid_cnt", sv_cnt - sv0, bad ? 0 : 1);
        check("frame_err_cnt", fe_cnt - fe0, bad ? 1 : 0);
        check("scan_code", SCAN_CODE, m_code);
        if (sv_cnt - sv0 == 1) check("kb_at_strobe", kb_at_sv, kb_model(A));
        check("kb", KB, kb_model(A));
    endtask

    task automatic set_a(logic [7:0] a);
        A = a;
        @(negedge CLK14);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK14);
        RESET = 1'b0;
        model_reset();
        @(negedge CLK14);
    endtask

    initial begin
        int fe0;
        logic [7:0] b;
        do_reset();
        A = 8'h00;
        @(negedge CLK14);
        check("rst_kb", KB, 5'b11111);
        check("rst_code", SCAN_CODE, 8'h00);
        check("rst_valid", SCAN_VALID, 1'b0);
        check("rst_err", FRAME_ERR, 1'b0);

        set_a(8'hFD);
        frame(8'h1C, 1'b0);
        check("a_press", KB, 5'b11110);
        frame(8'hF0, 1'b0);
        frame(8'h1C, 1'b0);
        check("a_release", KB, 5'b11111);

        frame(8'h12, 1'b0);
        frame(8'h16, 1'b0);
        set_a(8'h00); check("cs1_all", KB, 5'b11110);
        set_a(8'hF7); check("cs1_row3", KB, 5'b11110);
        set_a(8'hFF); check("cs1_none", KB, 5'b11111);
        set_a(8'hFE); check("cs1_row0", KB, 5'b11110);
        frame(8'hF0, 1'b0); frame(8'h12, 1'b0);
        frame(8'hF0, 1'b0); frame(8'h16, 1'b0);

        set_a(8'hFD);
        frame(8'h1C, 1'b1);
        check("bad_par_kb", KB, 5'b11111);
        frame(8'h1C, 1'b0);
        frame(8'hF0, 1'b0);
        frame(8'h1C, 1'b0);
        check("after_err_release", KB, 5'b11111);

        fe0 = fe_cnt;
        ps2_bit(1'b1);
        model_apply(8'h00, 1'b0);
        repeat (20) @(posedge CLK14);
        @(negedge CLK14);
        check("start_err", fe_cnt - fe0, 1);

        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TIMEOUT_CYC + 10) @(posedge CLK14);
        model_apply(8'h00, 1'b0);
        @(negedge CLK14);
        check("timeout_err", fe_cnt - fe0, 1);
        set_a(8'h7F);
        frame(8'h29, 1'b0);
        check("space_press", KB, 5'b11110);

        frame(8'h1C, 1'b0); frame(8'h1B, 1'b0); frame(8'h23, 1'b0);
        set_a(8'h00);
        check("three_keys", KB, kb_model(8'h00));
        frame(8'hFF, 1'b0);
        check("overrun_clear", KB, 5'b11111);

        frame(8'h1C, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        do_reset();
        check("midrst_code", SCAN_CODE, 8'h00);
        check("midrst_kb", KB, 5'b11111);
        set_a(8'hFD);
        frame(8'h1C, 1'b0);
        check("post_rst_press", KB, 5'b11110);

        do_reset();
        frame(8'hE0, 1'b0);
        frame(8'h75, 1'b0);
`ifdef PS2_CURSOR_KEYS_EN
        set_a(8'hFE); check("up_cs", KB, 5'b11110);
        set_a(8'hEF); check("up_7", KB, 5'b10111);
`else
        set_a(8'hFE); check("up_cs", KB, 5'b11111);
        set_a(8'hEF); check("up_7", KB, 5'b11111);
`endif
        frame(8'hE0, 1'b0); frame(8'hF0, 1'b0); frame(8'h75, 1'b0);
        set_a(8'h00); check("up_release", KB, 5'b11111);

        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 11);
            if (r == 0)      b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = 8'($urandom);
            else if (r == 3) b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'h66;
            else if (r == 4) b = 8'h6B + 8'($urandom_range(0, 1) * 7);
            else             b = keys[$urandom_range(0, 39)];
            A = 8'($urandom);
            frame(b, $urandom_range(0, 9) == 0);
            for (int k = 0; k < 2; k++) begin
                set_a(8'($urandom));
                check("rand_kb", KB, kb_model(A));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
